// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises the 5 Rs / 10 Rs lines, debounces them and
// emits one single-cycle coin code per physical coin, holding it while downstream is busy.
module coin_acceptor #(
   parameter int DEBOUNCE = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             raw_5,
   input  logic             raw_10,
   input  logic             hold,
   output logic [1:0]       coin,
   output logic             reject,
   output logic             busy,
   output logic [CNT_W-1:0] accepted_cnt
);

   // state   | meaning
   // IDLE    | armed, waiting for a sensor line
   // QUAL    | one line high, counting stable samples of the candidate
   // PEND    | coin qualified, waiting for hold to drop
   // RELEASE | waiting for both lines low for DEBOUNCE samples before re-arming
   typedef enum logic [1:0] {IDLE, QUAL, PEND, RELEASE} state_t;

   localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t           state, state_nxt;
   logic [1:0]       sync_5, sync_10;
   logic             s5, s10;
   logic [1:0]       pattern;
   logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
   logic [1:0]       cand, cand_nxt;
   logic [1:0]       coin_nxt;
   logic             reject_nxt;
   logic             qualified;

   assign s5      = sync_5[1];
   assign s10     = sync_10[1];
   assign pattern = {s10, s5};

   // deb_cnt is a down-counter holding the samples still needed; terminal count is 1
   assign qualified = (state == QUAL) && (pattern == cand) && (deb_cnt == ONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_5       <= 2'b00;
         sync_10      <= 2'b00;
         state        <= IDLE;
         deb_cnt      <= '0;
         cand         <= 2'b00;
         coin         <= 2'b00;
         reject       <= 1'b0;
         busy         <= 1'b0;
         accepted_cnt <= '0;
      end else begin
         sync_5  <= {sync_5[0], raw_5};
         sync_10 <= {sync_10[0], raw_10};
         state   <= state_nxt;
         deb_cnt <= deb_cnt_nxt;
         cand    <= cand_nxt;
         coin    <= coin_nxt;
         reject  <= reject_nxt;
         busy    <= (state_nxt != IDLE);
         if (coin_nxt != 2'b00)
            accepted_cnt <= accepted_cnt + ONE;
      end
   end

   always_comb begin
      state_nxt   = state;
      deb_cnt_nxt = deb_cnt;
      cand_nxt    = cand;
      case (state)
         IDLE: begin
            if (s5 && s10) begin
               state_nxt   = RELEASE;
               deb_cnt_nxt = DEB_TC;
            end else if (s5 || s10) begin
               state_nxt   = QUAL;
               cand_nxt    = pattern;
               deb_cnt_nxt = DEB_TC - ONE;
            end
         end
         QUAL: begin
            if (s5 && s10) begin
               state_nxt   = RELEASE;
               deb_cnt_nxt = DEB_TC;
            end else if (pattern == cand) begin
               if (qualified) begin
                  state_nxt   = hold ? PEND : RELEASE;
                  deb_cnt_nxt = DEB_TC;
               end else begin
                  deb_cnt_nxt = deb_cnt - ONE;
               end
            end else begin
               state_nxt   = IDLE;
               deb_cnt_nxt = '0;
            end
         end
         PEND: begin
            if (!hold) begin
               state_nxt   = RELEASE;
               deb_cnt_nxt = DEB_TC;
            end
         end
         RELEASE: begin
            if (s5 || s10) begin
               deb_cnt_nxt = DEB_TC;
            end else if (deb_cnt == ONE) begin
               state_nxt   = IDLE;
               deb_cnt_nxt = '0;
            end else begin
               deb_cnt_nxt = deb_cnt - ONE;
            end
         end
         default: begin
            state_nxt   = IDLE;
            deb_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      coin_nxt   = 2'b00;
      reject_nxt = 1'b0;
      case (state)
         IDLE:    reject_nxt = s5 && s10;
         QUAL: begin
            reject_nxt = s5 && s10;
            if (qualified && !hold)
               coin_nxt = cand;
         end
         PEND:    if (!hold) coin_nxt = cand;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised and directed bench for coin_acceptor, checked every cycle against
// an event-level model of the coin rules (DEBOUNCE=4, CNT_W=8).
module tb_coin_acceptor;

   localparam int DEB = 4;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          reset, raw_5, raw_10, hold;
   logic [1:0]    coin;
   logic          reject, busy;
   logic [CW-1:0] accepted_cnt;

   int total = 0;
   int bad   = 0;
   int n_coins = 0;
   int n_rej   = 0;

   coin_acceptor #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .raw_5(raw_5), .raw_10(raw_10), .hold(hold),
      .coin(coin), .reject(reject), .busy(busy), .accepted_cnt(accepted_cnt)
   );

   always #5 clk = ~clk;

   // reference model: sensor samples after a 2-cycle delay line, plus the coin rules
   logic [1:0] m_d5 = 2'b00, m_d10 = 2'b00;
   bit         armed = 1'b1;
   bit         pending = 1'b0;
   int         qual_len = 0;
   int         low_run = 0;
   logic [1:0] cand = 2'b00;
   int         m_cnt = 0;
   logic [1:0] e_coin = 2'b00;
   logic       e_rej = 1'b0;
   logic       e_busy = 1'b0;

   task automatic emit_coin();
      e_coin  = cand;
      m_cnt   = (m_cnt + 1) % (1 << CW);
      armed   = 1'b0;
      low_run = 0;
   endtask

   task automatic model_edge(input logic r5, input logic r10, input logic h, input logic rst);
      logic s5, s10;
      s5 = m_d5[1];
      s10 = m_d10[1];
      e_coin = 2'b00;
      e_rej  = 1'b0;
      if (rst) begin
         m_d5 = 2'b00; m_d10 = 2'b00;
         armed = 1'b1; pending = 1'b0; qual_len = 0; low_run = 0;
         cand = 2'b00; m_cnt = 0;
      end else begin
         if (pending) begin
            if (!h) begin
               pending = 1'b0;
               emit_coin();
            end
         end else if (!armed) begin
            if (s5 || s10) low_run = 0;
            else begin
               low_run++;
               if (low_run == DEB) armed = 1'b1;
            end
         end else if (s5 && s10) begin
            e_rej = 1'b1; armed = 1'b0; low_run = 0; qual_len = 0;
         end else if (qual_len == 0) begin
            if (s5 || s10) begin
               cand = {s10, s5};
               qual_len = 1;
            end
         end else if ({s10, s5} == cand) begin
            qual_len++;
            if (qual_len == DEB) begin
               qual_len = 0;
               if (h) pending = 1'b1;
               else emit_coin();
            end
         end else begin
            qual_len = 0;
         end
         m_d5  = {m_d5[0], r5};
         m_d10 = {m_d10[0], r10};
      end
      e_busy = pending || !armed || (qual_len > 0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r5, input logic r10, input logic h, input logic rst);
      raw_5 = r5; raw_10 = r10; hold = h; reset = rst;
      @(posedge clk);
      model_edge(r5, r10, h, rst);
      #1;
      chk("coin", {30'd0, coin}, {30'd0, e_coin});
      chk("reject", {31'd0, reject}, {31'd0, e_rej});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("accepted_cnt", {24'd0, accepted_cnt}, m_cnt);
      if (coin != 2'b00) n_coins++;
      if (reject) n_rej++;
   endtask

   task automatic steps(input int n, input logic r5, input logic r10, input logic h);
      for (int i = 0; i < n; i++) step(r5, r10, h, 1'b0);
   endtask

   initial begin
      int c0, rj0, hold_len;
      logic [1:0] p;
      logic h;
      raw_5 = 0; raw_10 = 0; hold = 0; reset = 1;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("reset_coin", {30'd0, coin}, 0);
      chk("reset_cnt", {24'd0, accepted_cnt}, 0);

      // single 5 Rs coin: coin=01 visible after edge 5
      c0 = n_coins;
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 0);
         if (i == 5) chk("t1_coin_at_5", {30'd0, coin}, 1);
         else chk("t1_no_coin", {30'd0, coin}, 0);
      end
      steps(8, 0, 0, 0);
      chk("t1_count", n_coins - c0, 1);
      chk("t1_cnt", {24'd0, accepted_cnt}, 1);
      chk("t1_idle", {31'd0, busy}, 0);

      // glitch on 10 Rs
      c0 = n_coins; rj0 = n_rej;
      steps(2, 0, 1, 0);
      steps(8, 0, 0, 0);
      chk("t2_coins", n_coins - c0, 0);
      chk("t2_rej", n_rej - rj0, 0);
      chk("t2_idle", {31'd0, busy}, 0);

      // double sensor
      c0 = n_coins; rj0 = n_rej;
      steps(6, 1, 1, 0);
      steps(8, 0, 0, 0);
      chk("t3_rej", n_rej - rj0, 1);
      chk("t3_coins", n_coins - c0, 0);

      // 10 Rs coin held back by hold
      c0 = n_coins;
      steps(8, 0, 1, 1);
      steps(7, 0, 0, 1);
      step(0, 0, 0, 0);
      chk("t4_coin_now", {30'd0, coin}, 2);
      steps(8, 0, 0, 0);
      chk("t4_count", n_coins - c0, 1);

      // long 5 Rs then a second coin after a 4-cycle gap
      c0 = n_coins;
      steps(50, 1, 0, 0);
      chk("t5_first", n_coins - c0, 1);
      steps(4, 0, 0, 0);
      steps(8, 1, 0, 0);
      steps(8, 0, 0, 0);
      chk("t5_second", n_coins - c0, 2);

      // reset while pending
      c0 = n_coins;
      steps(8, 1, 0, 1);
      chk("t6_busy_pend", {31'd0, busy}, 1);
      step(1, 0, 1, 1);
      chk("t6_rst_coin", {30'd0, coin}, 0);
      chk("t6_rst_busy", {31'd0, busy}, 0);
      chk("t6_rst_cnt", {24'd0, accepted_cnt}, 0);
      steps(10, 0, 0, 0);
      chk("t6_no_coin", n_coins - c0, 0);

      // 256 coins wrap the counter
      for (int k = 0; k < 256; k++) begin
         steps(5, 1, 0, 0);
         steps(6, 0, 0, 0);
      end
      chk("t7_wrap", {24'd0, accepted_cnt}, 0);

      // random segments
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: p = 2'b00;
            4, 5, 6:    p = 2'b01;
            7, 8:       p = 2'b10;
            default:    p = 2'b11;
         endcase
         h = ($urandom_range(0, 3) == 0);
         hold_len = $urandom_range(1, 8);
         if ($urandom_range(0, 99) == 0) step(p[0], p[1], h, 1'b1);
         steps(hold_len, p[0], p[1], h);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage feeding the vending FSM's `coin[1:0]` input.
- Synchronises the two raw coin-mechanism sensor lines (5 Rs, 10 Rs), debounces and qualifies them, rejects double-sensor events, and emits exactly one single-cycle coin code per physical coin.
- Holds one qualified coin while the downstream FSM is busy (hold high), so coins are never lost.

Parameters:
- DEBOUNCE, 8, consecutive stable synchronised samples required to qualify a coin and to re-arm after release (legal range 2..255).
- CNT_W, 8, width of the debounce counter and of the accepted-coin counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- raw_5  input  1  asynchronous 5 Rs sensor line, high while a coin is present
- raw_10  input  1  asynchronous 10 Rs sensor line, high while a coin is present
- hold  input  1  downstream not ready to accept a coin (high while the FSM is in S15, DISP or CHG)
- coin  output  2  registered coin code: 00 none, 01 5 Rs, 10 10 Rs; never drives 11
- reject  output  1  registered single-cycle pulse on a double-sensor event
- busy  output  1  registered; high whenever the state is not IDLE
- accepted_cnt  output  CNT_W  count of coins emitted, wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, active-high) forces, on the next edge:
  - both 2-flop synchronisers to 0
  - state to IDLE and both counters to 0
  - candidate register cleared
  - coin=00, reject=0, busy=0, accepted_cnt=0
  - any pending coin is discarded
- Sampling: every FSM decision uses only the synchroniser outputs s5/s10; the raw lines carry 2 cycles of latency.
- coin and reject are high for at most one cycle per event; both default to their inactive values every cycle.
- States and transitions:
  - IDLE:
    - exactly one of s5/s10 high: latch candidate (01 or 10), debounce count=1, go QUAL
    - both high: pulse reject, go RELEASE
    - neither high: stay
  - QUAL:
    - (s5,s10) equals the candidate pattern: increment count; when count reaches DEBOUNCE, the coin is qualified on that edge
    - qualified with hold=0: drive coin=candidate for one cycle, increment accepted_cnt, go RELEASE
    - qualified with hold=1: go PEND
    - both lines high: pulse reject, go RELEASE
    - any other pattern change (glitch drop or switch): go IDLE silently, clear count
  - PEND:
    - wait while hold=1; the sensor lines are ignored
    - first cycle with hold=0: drive coin=candidate, increment accepted_cnt, go RELEASE
  - RELEASE:
    - count consecutive samples with s5=s10=0; any high sample clears the count
    - after DEBOUNCE consecutive low samples: go IDLE
    - a second coin cannot be accepted until re-armed
- Latency: first raw high sampled at edge k → coin is high in the cycle following edge k+DEBOUNCE+1, provided hold=0 and the line stays stable.
- Rejection: a reject is never deferred by hold; reject and coin never assert in the same cycle.
- accepted_cnt: increments only when coin≠00; wraps from 2^CNT_W−1 to 0.
- Reset mid-operation (QUAL, PEND or RELEASE): return to IDLE with no coin emitted.

Test Plan:
- DEBOUNCE=4; raw_5 high for 10 cycles from edge 0, hold=0 → coin=01 for exactly one cycle after edge 5; accepted_cnt=1; busy returns low 4 cycles after s5 falls.
- raw_10 high for 2 cycles only (glitch) → no coin, no reject; state returns to IDLE; accepted_cnt unchanged.
- raw_5 and raw_10 rise on the same edge → reject pulses once; coin stays 00; no further event until both lines have been low for 4 cycles.
- hold=1 throughout qualification of a 10 Rs coin, released 7 cycles later → coin=10 on the first cycle after hold falls, exactly once.
- raw_5 held high for 50 cycles → exactly one coin=01; a second coin inserted after a 4-cycle low gap → second coin=01 emitted.
- Reset asserted in PEND → no coin ever emitted for that insertion; all outputs 0 the cycle after the reset edge; 256 accepted coins with CNT_W=8 → accepted_cnt wraps to 0.
